vga_box_compositor: RTL and testbench



---
 rtl/vga_box_compositor.sv | 178 +++++++++++++++++
 tb/tb_vga_box_compositor.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_box_compositor.sv
// Composites NUM_BOXES priority-ordered rectangles over a background colour.
// Box parameters are shadowed at frame boundaries; pixel path is two stages deep.
module vga_box_compositor #(
    parameter int NUM_BOXES  = 4,
    parameter int X_WIDTH    = 10,
    parameter int Y_WIDTH    = 9,
    parameter int HALF_WIDTH = 8,
    parameter int COLOR_BITS = 12
) (
    input  logic                             clk_25mHz,
    input  logic                             reset,
    input  logic [X_WIDTH-1:0]               x_in,
    input  logic [Y_WIDTH-1:0]               y_in,
    input  logic                             active_in,
    input  logic                             hSync_in,
    input  logic                             vSync_in,
    input  logic                             screenEnd,
    input  logic [NUM_BOXES*X_WIDTH-1:0]     box_cx,
    input  logic [NUM_BOXES*Y_WIDTH-1:0]     box_cy,
    input  logic [NUM_BOXES*HALF_WIDTH-1:0]  box_half,
    input  logic [NUM_BOXES*COLOR_BITS-1:0]  box_color,
    input  logic [NUM_BOXES-1:0]             box_en,
    input  logic [COLOR_BITS-1:0]            bg_color,
    output logic                             hSync,
    output logic                             vSync,
    output logic [COLOR_BITS-1:0]            colorOut,
    output logic                             collide,
    output logic                             collide_sticky,
    output logic [15:0]                      frame_count
);

    logic [NUM_BOXES*X_WIDTH-1:0]    sh_cx_q;
    logic [NUM_BOXES*Y_WIDTH-1:0]    sh_cy_q;
    logic [NUM_BOXES*HALF_WIDTH-1:0] sh_half_q;
    logic [NUM_BOXES*COLOR_BITS-1:0] sh_color_q;
    logic [NUM_BOXES-1:0]            sh_en_q;

    logic [NUM_BOXES-1:0][X_WIDTH-1:0] left_d, left_q, right_d, right_q;
    logic [NUM_BOXES-1:0][Y_WIDTH-1:0] top_d, top_q, bot_d, bot_q;
    logic [NUM_BOXES-1:0]              bnd_en_q;

    logic [X_WIDTH:0] cx_ext, hx_ext, x_lo, x_hi;
    logic [Y_WIDTH:0] cy_ext, hy_ext, y_lo, y_hi;

    logic [NUM_BOXES-1:0]  hit_d, hit_q;
    logic                  act1_q, hs1_q, vs1_q, ovl_d, ovl_q;
    logic                  hs2_q, vs2_q;
    logic [COLOR_BITS-1:0] color_d, color_q;
    logic                  found;
    logic                  flag_d, flag_q, collide_d, collide_q, sticky_d, sticky_q;
    logic [15:0]           frame_q;

    // Bounds are evaluated one bit wider so underflow/overflow is visible and clamped.
    always_comb begin
        left_d  = '0;
        right_d = '0;
        top_d   = '0;
        bot_d   = '0;
        cx_ext  = '0;
        hx_ext  = '0;
        x_lo    = '0;
        x_hi    = '0;
        cy_ext  = '0;
        hy_ext  = '0;
        y_lo    = '0;
        y_hi    = '0;
        for (int unsigned i = 0; i < NUM_BOXES; i++) begin
            cx_ext     = {1'b0, sh_cx_q[i*X_WIDTH +: X_WIDTH]};
            hx_ext     = (X_WIDTH+1)'(sh_half_q[i*HALF_WIDTH +: HALF_WIDTH]);
            x_lo       = cx_ext - hx_ext;
            x_hi       = cx_ext + hx_ext;
            left_d[i]  = x_lo[X_WIDTH] ? '0 : x_lo[X_WIDTH-1:0];
            right_d[i] = x_hi[X_WIDTH] ? '1 : x_hi[X_WIDTH-1:0];
            cy_ext     = {1'b0, sh_cy_q[i*Y_WIDTH +: Y_WIDTH]};
            hy_ext     = (Y_WIDTH+1)'(sh_half_q[i*HALF_WIDTH +: HALF_WIDTH]);
            y_lo       = cy_ext - hy_ext;
            y_hi       = cy_ext + hy_ext;
            top_d[i]   = y_lo[Y_WIDTH] ? '0 : y_lo[Y_WIDTH-1:0];
            bot_d[i]   = y_hi[Y_WIDTH] ? '1 : y_hi[Y_WIDTH-1:0];
        end
    end

    always_comb begin
        hit_d = '0;
        for (int unsigned i = 0; i < NUM_BOXES; i++) begin
            hit_d[i] = bnd_en_q[i]
                     && (x_in >= left_q[i]) && (x_in <= right_q[i])
                     && (y_in >= top_q[i])  && (y_in <= bot_q[i]);
        end
    end

    generate
        if (NUM_BOXES > 1) begin : g_ovl
            assign ovl_d = hit_d[0] & hit_d[1] & active_in;
        end else begin : g_no_ovl
            assign ovl_d = 1'b0;
        end
    endgenerate

    always_comb begin
        color_d = bg_color;
        found   = 1'b0;
        for (int unsigned i = 0; i < NUM_BOXES; i++) begin
            if (!found && hit_q[i]) begin
                color_d = sh_color_q[i*COLOR_BITS +: COLOR_BITS];
                found   = 1'b1;
            end
        end
        if (!act1_q) color_d = '0;
    end

    // An overlap registered in the same cycle as screenEnd belongs to the closing frame.
    always_comb begin
        collide_d = screenEnd & (flag_q | ovl_q);
        flag_d    = screenEnd ? 1'b0 : (flag_q | ovl_q);
        sticky_d  = sticky_q | collide_d;
    end

    always_ff @(posedge clk_25mHz or posedge reset) begin
        if (reset) begin
            sh_cx_q    <= '0;
            sh_cy_q    <= '0;
            sh_half_q  <= '0;
            sh_color_q <= '0;
            sh_en_q    <= '0;
            left_q     <= '0;
            right_q    <= '0;
            top_q      <= '0;
            bot_q      <= '0;
            bnd_en_q   <= '0;
            hit_q      <= '0;
            act1_q     <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            ovl_q      <= 1'b0;
            hs2_q      <= 1'b1;
            vs2_q      <= 1'b1;
            color_q    <= '0;
            flag_q     <= 1'b0;
            collide_q  <= 1'b0;
            sticky_q   <= 1'b0;
            frame_q    <= '0;
        end else begin
            if (screenEnd) begin
                sh_cx_q    <= box_cx;
                sh_cy_q    <= box_cy;
                sh_half_q  <= box_half;
                sh_color_q <= box_color;
                sh_en_q    <= box_en;
                frame_q    <= frame_q + 16'd1;
            end
            left_q    <= left_d;
            right_q   <= right_d;
            top_q     <= top_d;
            bot_q     <= bot_d;
            bnd_en_q  <= sh_en_q;
            hit_q     <= hit_d;
            act1_q    <= active_in;
            hs1_q     <= hSync_in;
            vs1_q     <= vSync_in;
            ovl_q     <= ovl_d;
            hs2_q     <= hs1_q;
            vs2_q     <= vs1_q;
            color_q   <= color_d;
            flag_q    <= flag_d;
            collide_q <= collide_d;
            sticky_q  <= sticky_d;
        end
    end

    assign hSync          = hs2_q;
    assign vSync          = vs2_q;
    assign colorOut       = color_q;
    assign collide        = collide_q;
    assign collide_sticky = sticky_q;
    assign frame_count    = frame_q;

endmodule

// File: tb/tb_vga_box_compositor.sv
// Directed bench for vga_box_compositor: hand-computed pixel colours, sync delay,
// clamping, shadowing, collision reporting and frame counter wrap.
module tb_vga_box_compositor;

    localparam int NB = 4;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int HW = 8;
    localparam int CB = 12;

    logic                 clk_25mHz = 1'b0;
    logic                 reset = 1'b1;
    logic [XW-1:0]        x_in = '0;
    logic [YW-1:0]        y_in = '0;
    logic                 active_in = 1'b0;
    logic                 hSync_in = 1'b0;
    logic                 vSync_in = 1'b0;
    logic                 screenEnd = 1'b0;
    logic [NB*XW-1:0]     box_cx = '0;
    logic [NB*YW-1:0]     box_cy = '0;
    logic [NB*HW-1:0]     box_half = '0;
    logic [NB*CB-1:0]     box_color = '0;
    logic [NB-1:0]        box_en = '0;
    logic [CB-1:0]        bg_color = 12'h0F0;
    logic                 hSync, vSync;
    logic [CB-1:0]        colorOut;
    logic                 collide, collide_sticky;
    logic [15:0]          frame_count;

    int n_cmp = 0;
    int n_bad = 0;

    vga_box_compositor #(
        .NUM_BOXES(NB), .X_WIDTH(XW), .Y_WIDTH(YW), .HALF_WIDTH(HW), .COLOR_BITS(CB)
    ) dut (
        .clk_25mHz(clk_25mHz), .reset(reset),
        .x_in(x_in), .y_in(y_in), .active_in(active_in),
        .hSync_in(hSync_in), .vSync_in(vSync_in), .screenEnd(screenEnd),
        .box_cx(box_cx), .box_cy(box_cy), .box_half(box_half),
        .box_color(box_color), .box_en(box_en), .bg_color(bg_color),
        .hSync(hSync), .vSync(vSync), .colorOut(colorOut),
        .collide(collide), .collide_sticky(collide_sticky), .frame_count(frame_count)
    );

    always #20 clk_25mHz = ~clk_25mHz;

    task automatic set_box(input int i, input int cx, input int cy, input int half,
                           input logic [CB-1:0] col, input logic en);
        box_cx[i*XW +: XW]    = XW'(cx);
        box_cy[i*YW +: YW]    = YW'(cy);
        box_half[i*HW +: HW]  = HW'(half);
        box_color[i*CB +: CB] = col;
        box_en[i]             = en;
    endtask

    // Called at a falling edge; returns colorOut two cycles later.
    task automatic pix(input int x, input int y, input logic act, output logic [CB-1:0] c);
        x_in      = XW'(x);
        y_in      = YW'(y);
        active_in = act;
        @(negedge clk_25mHz);
        @(negedge clk_25mHz);
        c = colorOut;
    endtask

    task automatic check_pix(input string name, input int x, input int y, input logic act,
                             input logic [CB-1:0] exp);
        logic [CB-1:0] c;
        pix(x, y, act, c);
        n_cmp++;
        if (c !== exp) begin
            n_bad++;
            $display("FAIL %s (x=%0d y=%0d): colorOut=%h expected %h", name, x, y, c, exp);
        end
    endtask

    // One-cycle screenEnd; returns collide in the pulse cycle and the one after.
    task automatic end_frame(output logic c1, output logic c2);
        active_in = 1'b0;
        @(negedge clk_25mHz);
        screenEnd = 1'b1;
        @(negedge clk_25mHz);
        screenEnd = 1'b0;
        c1 = collide;
        @(negedge clk_25mHz);
        c2 = collide;
    endtask

    task automatic test_reset;
        hSync_in = 1'b0;
        vSync_in = 1'b0;
        repeat (3) @(negedge clk_25mHz);
        n_cmp++;
        if ({hSync, vSync} !== 2'b11) begin
            n_bad++; $display("FAIL reset_sync: got %b expected 11", {hSync, vSync});
        end
        n_cmp++;
        if (colorOut !== '0) begin
            n_bad++; $display("FAIL reset_color: got %h expected 000", colorOut);
        end
        n_cmp++;
        if ({collide, collide_sticky, frame_count} !== 18'd0) begin
            n_bad++; $display("FAIL reset_flags: got %b/%b/%h expected 0/0/0000",
                              collide, collide_sticky, frame_count);
        end
        reset = 1'b0;
        @(negedge clk_25mHz);
    endtask

    task automatic test_background_sync;
        logic [9:0] hp, vp;
        hp = 10'b1101001110;
        vp = 10'b0111011001;
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) begin
                n_cmp++;
                if ({hSync, vSync} !== {hp[i-2], vp[i-2]}) begin
                    n_bad++;
                    $display("FAIL sync_delay[%0d]: got %b expected %b", i,
                             {hSync, vSync}, {hp[i-2], vp[i-2]});
                end
            end
            hSync_in = hp[i];
            vSync_in = vp[i];
            @(negedge clk_25mHz);
        end
        hSync_in = 1'b1;
        vSync_in = 1'b1;
        check_pix("bg_visible", 100, 100, 1'b1, 12'h0F0);
        check_pix("bg_blank", 100, 100, 1'b0, 12'h000);
        check_pix("bg_corner", 639, 479, 1'b1, 12'h0F0);
    endtask

    task automatic test_box;
        logic c1, c2;
        set_box(0, 100, 100, 25, 12'h00F, 1'b1);
        check_pix("box_before_capture", 100, 100, 1'b1, 12'h0F0);
        end_frame(c1, c2);
        check_pix("box_x74", 74, 100, 1'b1, 12'h0F0);
        check_pix("box_x75", 75, 100, 1'b1, 12'h00F);
        check_pix("box_x125", 125, 100, 1'b1, 12'h00F);
        check_pix("box_x126", 126, 100, 1'b1, 12'h0F0);
        check_pix("box_y74", 100, 74, 1'b1, 12'h0F0);
        check_pix("box_y75", 100, 75, 1'b1, 12'h00F);
        check_pix("box_y125", 100, 125, 1'b1, 12'h00F);
        check_pix("box_y126", 100, 126, 1'b1, 12'h0F0);
        check_pix("box_blank", 100, 100, 1'b0, 12'h000);
        end_frame(c1, c2);
        n_cmp++;
        if ({c1, collide_sticky} !== 2'b00) begin
            n_bad++; $display("FAIL box_no_collide: collide/sticky=%b expected 00", {c1, collide_sticky});
        end
    endtask

    task automatic test_overlap;
        logic c1, c2;
        set_box(0, 200, 100, 10, 12'hF00, 1'b1);
        set_box(1, 210, 100, 10, 12'h00F, 1'b1);
        end_frame(c1, c2);
        check_pix("ovl_box0_only", 195, 100, 1'b1, 12'hF00);
        check_pix("ovl_region", 205, 100, 1'b1, 12'hF00);
        check_pix("ovl_box1_only", 215, 100, 1'b1, 12'h00F);
        n_cmp++;
        if ({collide, collide_sticky} !== 2'b00) begin
            n_bad++; $display("FAIL ovl_midframe: collide/sticky=%b expected 00", {collide, collide_sticky});
        end
        end_frame(c1, c2);
        n_cmp++;
        if ({c1, c2} !== 2'b10) begin
            n_bad++; $display("FAIL ovl_collide_pulse: got %b expected 10", {c1, c2});
        end
        n_cmp++;
        if (collide_sticky !== 1'b1) begin
            n_bad++; $display("FAIL ovl_sticky: got %b expected 1", collide_sticky);
        end
        end_frame(c1, c2);
        n_cmp++;
        if ({c1, c2, collide_sticky} !== 3'b001) begin
            n_bad++; $display("FAIL ovl_next_frame: got %b expected 001", {c1, c2, collide_sticky});
        end
    endtask

    task automatic test_clamp;
        logic c1, c2;
        set_box(1, 0, 0, 0, 12'h000, 1'b0);
        set_box(0, 10, 100, 25, 12'hABC, 1'b1);
        end_frame(c1, c2);
        check_pix("clampL_x0", 0, 100, 1'b1, 12'hABC);
        check_pix("clampL_x35", 35, 100, 1'b1, 12'hABC);
        check_pix("clampL_x36", 36, 100, 1'b1, 12'h0F0);
        check_pix("clampL_x1015", 1015, 100, 1'b1, 12'h0F0);
        set_box(0, 1020, 100, 25, 12'h123, 1'b1);
        end_frame(c1, c2);
        check_pix("clampR_x1023", 1023, 100, 1'b1, 12'h123);
        check_pix("clampR_x995", 995, 100, 1'b1, 12'h123);
        check_pix("clampR_x994", 994, 100, 1'b1, 12'h0F0);
        check_pix("clampR_x0", 0, 100, 1'b1, 12'h0F0);
        set_box(0, 10, 5, 0, 12'h555, 1'b1);
        end_frame(c1, c2);
        check_pix("single_pixel", 10, 5, 1'b1, 12'h555);
        check_pix("single_pixel_next", 11, 5, 1'b1, 12'h0F0);
    endtask

    task automatic test_midframe;
        logic c1, c2;
        set_box(0, 300, 100, 5, 12'hF0F, 1'b1);
        end_frame(c1, c2);
        check_pix("mid_old_pos", 300, 100, 1'b1, 12'hF0F);
        set_box(0, 500, 100, 5, 12'hF0F, 1'b1);
        check_pix("mid_old_pos_hold", 300, 100, 1'b1, 12'hF0F);
        check_pix("mid_new_pos_absent", 500, 100, 1'b1, 12'h0F0);
        end_frame(c1, c2);
        check_pix("mid_new_pos", 500, 100, 1'b1, 12'hF0F);
        check_pix("mid_old_pos_gone", 300, 100, 1'b1, 12'h0F0);
    endtask

    task automatic test_reset_midframe;
        check_pix("rst_pre_drawn", 500, 100, 1'b1, 12'hF0F);
        #5 reset = 1'b1;
        #1;
        n_cmp++;
        if ({colorOut, collide_sticky, frame_count, hSync} !== {12'h000, 1'b0, 16'h0000, 1'b1}) begin
            n_bad++;
            $display("FAIL rst_async: color=%h sticky=%b frames=%h hSync=%b expected 000/0/0000/1",
                     colorOut, collide_sticky, frame_count, hSync);
        end
        @(negedge clk_25mHz);
        reset = 1'b0;
        check_pix("rst_box_absent", 500, 100, 1'b1, 12'h0F0);
        begin
            logic c1, c2;
            end_frame(c1, c2);
        end
        check_pix("rst_box_back", 500, 100, 1'b1, 12'hF0F);
    endtask

    task automatic test_frame_wrap;
        box_en = '0;
        @(negedge clk_25mHz);
        reset = 1'b1;
        @(negedge clk_25mHz);
        reset = 1'b0;
        n_cmp++;
        if (frame_count !== 16'h0000) begin
            n_bad++; $display("FAIL wrap_start: frame_count=%h expected 0000", frame_count);
        end
        screenEnd = 1'b1;
        repeat (3) @(negedge clk_25mHz);
        n_cmp++;
        if (frame_count !== 16'h0003) begin
            n_bad++; $display("FAIL wrap_count3: frame_count=%h expected 0003", frame_count);
        end
        repeat (65532) @(negedge clk_25mHz);
        n_cmp++;
        if (frame_count !== 16'hFFFF) begin
            n_bad++; $display("FAIL wrap_ffff: frame_count=%h expected FFFF", frame_count);
        end
        @(negedge clk_25mHz);
        screenEnd = 1'b0;
        n_cmp++;
        if (frame_count !== 16'h0000) begin
            n_bad++; $display("FAIL wrap_zero: frame_count=%h expected 0000", frame_count);
        end
        @(negedge clk_25mHz);
        n_cmp++;
        if (frame_count !== 16'h0000) begin
            n_bad++; $display("FAIL wrap_hold: frame_count=%h expected 0000", frame_count);
        end
    endtask

    initial begin
        @(negedge clk_25mHz);
        test_reset;
        test_background_sync;
        test_box;
        test_overlap;
        test_clamp;
        test_midframe;
        test_reset_midframe;
        test_frame_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
